// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter owner and single-clock phase sequencer for the cpu15 core.
//   Each instruction is stepped through FT -> DC -> EX -> WB, one cycle each.
//   PHASE is one-hot and is used downstream as clock enables. Control flow
//   (sequential, jmp, je, hlt) is resolved when leaving WB.
//
// Ports:
//   CLK        in   system clock, all state changes on the rising edge
//   RESET_N    in   synchronous active-low reset
//   RUN        in   run enable, sampled in IDLE and WB only
//   PROM_OUT   in   15-bit instruction word, latched into IR during DC
//   FLAG_EQ    in   equality flag from execute, sampled in WB
//   P_COUNT    out  8-bit program counter to instruction ROM
//   PHASE      out  one-hot strobe {WB, EX, DC, FT}, zero in IDLE/HALT
//   HALTED     out  high once hlt has retired
//   INSTR_CNT  out  saturating count of retired instructions
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUN,
  input  logic [14:0]      PROM_OUT,
  input  logic             FLAG_EQ,
  output logic [7:0]       P_COUNT,
  output logic [3:0]       PHASE,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FT,
    S_DC,
    S_EX,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JE  = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [3:0] PH_NONE = 4'b0000;
  localparam logic [3:0] PH_FT   = 4'b0001;
  localparam logic [3:0] PH_DC   = 4'b0010;
  localparam logic [3:0] PH_EX   = 4'b0100;
  localparam logic [3:0] PH_WB   = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [14:0]      ir_q;
  logic [7:0]       pc_q;
  logic [3:0]       phase_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       opcode;
  logic             take_jump;
  logic [7:0]       pc_d;
  logic [CNT_W-1:0] cnt_d;

  // Decode works only from the latched IR; PROM_OUT may change after DC.
  always_comb begin
    opcode    = ir_q[14:11];
    take_jump = (opcode == OP_JMP) || ((opcode == OP_JE) && FLAG_EQ);
    pc_d      = take_jump ? ir_q[7:0] : pc_q + 8'd1;
    // Saturate rather than wrap so a long-running program never reads as "few".
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      pc_q     <= PC_RESET;
      phase_q  <= PH_NONE;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (RUN) begin
            state_q <= S_FT;
            phase_q <= PH_FT;
          end
        end
        S_FT: begin
          state_q <= S_DC;
          phase_q <= PH_DC;
        end
        S_DC: begin
          ir_q    <= PROM_OUT;
          state_q <= S_EX;
          phase_q <= PH_EX;
        end
        S_EX: begin
          state_q <= S_WB;
          phase_q <= PH_WB;
        end
        S_WB: begin
          cnt_q <= cnt_d;
          if (opcode == OP_HLT) begin
            // PC stays on the hlt itself; HALT is left only via reset.
            halted_q <= 1'b1;
            state_q  <= S_HALT;
            phase_q  <= PH_NONE;
          end else begin
            pc_q <= pc_d;
            if (RUN) begin
              state_q <= S_FT;
              phase_q <= PH_FT;
            end else begin
              state_q <= S_IDLE;
              phase_q <= PH_NONE;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
          phase_q <= PH_NONE;
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= PH_NONE;
        end
      endcase
    end
  end

  assign P_COUNT   = pc_q;
  assign PHASE     = phase_q;
  assign HALTED    = halted_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. An instruction-level reference model
//   (position within the 4-cycle instruction, PC, retire count, halt flag) is
//   stepped alongside the DUT every cycle and all outputs are compared on the
//   falling edge. PROM_OUT carries the ROM word only in the DC cycle and random
//   junk otherwise, so any decode from live PROM_OUT shows up as a wrong PC.
//   A second instance (PC_RESET=FF, CNT_W=2) covers PC wrap and count
//   saturation.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN = 1'b0;
  logic [14:0] PROM_OUT = '0;
  logic        FLAG_EQ = 1'b0;
  logic [7:0]  P_COUNT;
  logic [3:0]  PHASE;
  logic        HALTED;
  logic [15:0] INSTR_CNT;

  logic        rstn2 = 1'b0;
  logic        run2 = 1'b0;
  logic [14:0] prom2 = '0;
  logic        flag2 = 1'b0;
  logic [7:0]  pc2;
  logic [3:0]  phase2;
  logic        halted2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_RESET(8'h00), .CNT_W(16)) dut (
    .CLK       (clk),
    .RESET_N   (RESET_N),
    .RUN       (RUN),
    .PROM_OUT  (PROM_OUT),
    .FLAG_EQ   (FLAG_EQ),
    .P_COUNT   (P_COUNT),
    .PHASE     (PHASE),
    .HALTED    (HALTED),
    .INSTR_CNT (INSTR_CNT)
  );

  pc_sequencer #(.PC_RESET(8'hFF), .CNT_W(2)) dut_wrap (
    .CLK       (clk),
    .RESET_N   (rstn2),
    .RUN       (run2),
    .PROM_OUT  (prom2),
    .FLAG_EQ   (flag2),
    .P_COUNT   (pc2),
    .PHASE     (phase2),
    .HALTED    (halted2),
    .INSTR_CNT (cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, one instruction at a time.
  logic [14:0] rom [256];
  bit          m_run;      // inside an instruction (FT..WB)
  int          m_k;        // 0=FT 1=DC 2=EX 3=WB
  bit          m_halt;
  logic [7:0]  m_pc;
  int          m_cnt;
  logic [14:0] m_ir;
  int          je_seen;
  bit          checks_on = 0;

  task automatic step(input bit rstn, input bit run, input bit flag);
    bit         in_dc;
    logic [3:0] op;
    @(negedge clk);
    if (checks_on) begin
      check("phase", {28'd0, PHASE}, m_run ? (32'd1 << m_k) : 32'd0);
      check("pc", {24'd0, P_COUNT}, {24'd0, m_pc});
      check("halted", {31'd0, HALTED}, {31'd0, m_halt});
      check("cnt", {16'd0, INSTR_CNT}, m_cnt);
    end
    in_dc    = m_run && (m_k == 1);
    RESET_N  = rstn;
    RUN      = run;
    FLAG_EQ  = flag;
    PROM_OUT = in_dc ? rom[m_pc] : 15'($urandom);
    if (!rstn) begin
      m_run = 0; m_k = 0; m_halt = 0; m_pc = 8'h00; m_cnt = 0; m_ir = '0;
    end else if (m_halt) begin
      // absorbing
    end else if (!m_run) begin
      if (run) begin
        m_run = 1; m_k = 0;
      end
    end else if (m_k < 3) begin
      if (m_k == 1) m_ir = PROM_OUT;
      m_k++;
    end else begin
      op    = m_ir[14:11];
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      $display("retire pc=%02h ir=%04h flag=%0d cnt=%0d", m_pc, m_ir, flag, m_cnt);
      if (op == 4'b1111) begin
        m_halt = 1; m_run = 0;
      end else begin
        if (op == 4'b1011) je_seen++;
        if (op == 4'b1100 || (op == 4'b1011 && flag)) m_pc = m_ir[7:0];
        else m_pc = m_pc + 8'd1;
        m_run = run; m_k = 0;
      end
    end
  endtask

  initial begin
    bit dropped;
    int halt_cycles;
    int r;
    logic [14:0] w;

    // 1. reset and idle
    step(0, 0, 0);
    checks_on = 1;
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("idle_pc", {24'd0, P_COUNT}, 32'h00);
    check("idle_phase", {28'd0, PHASE}, 32'h0);
    $display("reset/idle done");

    // 2-5. sequential run, je not taken, jmp, je taken, hlt
    for (int i = 0; i < 256; i++) rom[i] = 15'h0000;
    rom[8'h0C] = 15'b1011_0000_0001_110;
    rom[8'h0D] = 15'b1100_0000_0001_000;
    rom[8'h0E] = 15'h7800;
    je_seen = 0;
    for (int i = 0; i < 400 && !m_halt; i++) step(1, 1, je_seen >= 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1);
    check("halt_flag", {31'd0, HALTED}, 32'd1);
    check("halt_pc", {24'd0, P_COUNT}, 32'h0E);
    check("halt_phase", {28'd0, PHASE}, 32'h0);
    check("halt_cnt", {16'd0, INSTR_CNT}, 32'd20);
    step(0, 1, 0);
    step(1, 0, 0);
    check("unhalt_pc", {24'd0, P_COUNT}, 32'h00);
    check("unhalt_flag", {31'd0, HALTED}, 32'd0);
    check("unhalt_cnt", {16'd0, INSTR_CNT}, 32'd0);
    $display("jump/halt sequence done");

    // 6. RUN dropped in DC of the nop at 0x05, resume, reset during EX
    dropped = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_k == 1 && m_pc == 8'h05) dropped = 1;
      step(1, !dropped, 0);
      if (dropped && !m_run) break;
    end
    step(1, 0, 0);
    step(1, 0, 0);
    check("park_pc", {24'd0, P_COUNT}, 32'h06);
    check("park_phase", {28'd0, PHASE}, 32'h0);
    step(1, 1, 0);
    step(1, 1, 0);
    check("resume_phase", {28'd0, PHASE}, 32'h1);
    for (int i = 0; i < 10 && !(m_run && m_k == 2); i++) step(1, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check("exrst_pc", {24'd0, P_COUNT}, 32'h00);
    check("exrst_cnt", {16'd0, INSTR_CNT}, 32'd0);
    $display("run-drop/mid-reset done");

    // random program and stimulus
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      rom[i] = {4'b1100, 3'b000, 8'($urandom)};
      else if (r < 40) rom[i] = {4'b1011, 3'b000, 8'($urandom)};
      else if (r < 43) rom[i] = {4'b1111, 11'($urandom)};
      else begin
        w = 15'($urandom);
        if (w[14:11] == 4'b1100 || w[14:11] == 4'b1011 || w[14:11] == 4'b1111) w[14:11] = 4'h0;
        rom[i] = w;
      end
    end
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      step(!(halt_cycles >= 20 || $urandom_range(0, 299) == 0),
           $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
    end
    step(0, 0, 0);
    $display("random phase done");

    // PC wrap from 0xFF and 2-bit count saturation on the second instance
    checks_on = 0;
    rstn2 = 1'b0;
    run2  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn2 = 1'b1;
    @(negedge clk);
    check("wrap_rst_pc", {24'd0, pc2}, 32'hFF);
    check("wrap_rst_cnt", {30'd0, cnt2}, 32'd0);
    run2 = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      repeat (4) @(negedge clk);
      check("wrap_pc", {24'd0, pc2}, (32'hFF + i) & 32'hFF);
      check("wrap_cnt", {30'd0, cnt2}, (i < 3) ? i : 3);
      check("wrap_phase", {28'd0, phase2}, 32'h1);
      $display("wrap instr %0d pc=%02h cnt=%0d", i, pc2, cnt2);
    end
    run2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
